// File: rtl/myproject_dense_pkg.sv
// -----------------------------------------------------------------------------
// myproject_dense_pkg
// Shared definitions for the dense-layer accumulation stage:
//   - default widths of the multiplier product, the bias and the layer output
//   - acc_state_t : accumulation FSM states (ACC, HOLD)
//   - clog2       : elaboration-time ceiling log2 helper
// -----------------------------------------------------------------------------
package myproject_dense_pkg;

   localparam int PROD_W = 18;
   localparam int BIAS_W = 24;
   localparam int OUT_W  = 16;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// -----------------------------------------------------------------------------
// myproject_round_sat
// Combinational finalise unit: adds the half-LSB rounding term (round half
// toward +inf), arithmetic right shift by FRAC_SHIFT, then saturates to OUT_W.
// With DENSE_ACC_RELU_EN defined, negative saturated results become 0 and the
// saturation flag is cleared for them.
// Ports:
//   acc_i  : signed accumulator value (ACC_W)
//   data_o : signed finalised result (OUT_W)
//   sat_o  : set when the result was clipped
// -----------------------------------------------------------------------------
module myproject_round_sat #(
   parameter int ACC_W      = 25,
   parameter int FRAC_SHIFT = 6,
   parameter int OUT_W      = 16
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    sat_o
);

   localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] RND = (FRAC_SHIFT > 0) ? (ONE <<< RND_SH) : '0;

   logic signed [ACC_W:0]   r_sh;
   logic signed [OUT_W-1:0] sat_data;
   logic                    sat_flag;

   // One extra bit keeps the rounding add from wrapping.
   function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + RND;
      return s >>> FRAC_SHIFT;
   endfunction

   // The value fits when every bit above the output sign bit equals it.
   function automatic void saturate(input  logic signed [ACC_W:0]   r,
                                    output logic signed [OUT_W-1:0] d,
                                    output logic                    s);
      logic fits;
      fits = (&r[ACC_W:OUT_W-1]) || !(|r[ACC_W:OUT_W-1]);
      if (fits) begin
         d = r[OUT_W-1:0];
         s = 1'b0;
      end else begin
         d = r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
         s = 1'b1;
      end
   endfunction

   always_comb begin
      r_sh = round_shift(acc_i);
      saturate(r_sh, sat_data, sat_flag);
      data_o = sat_data;
      sat_o  = sat_flag;
`ifdef DENSE_ACC_RELU_EN
      if (sat_data[OUT_W-1]) begin
         data_o = '0;
         sat_o  = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/myproject_dense_acc.sv
// -----------------------------------------------------------------------------
// myproject_dense_acc
// Accumulates N_IN signed products per output neuron plus a per-neuron bias,
// then rounds/shifts/saturates into a valid/ready output register. A completed
// sum can be parked in the accumulator (HOLD) while the output register is
// still occupied, so the input only stalls when both hold results.
// Optional feature macro: DENSE_ACC_RELU_EN (fused ReLU in the finalise unit).
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready / in_prod / in_bias : product stream (bias taken with
//                                             the first product of a neuron)
//   out_valid / out_ready / out_data / out_sat : result port
// -----------------------------------------------------------------------------
module myproject_dense_acc #(
   parameter int PROD_W     = myproject_dense_pkg::PROD_W,
   parameter int BIAS_W     = myproject_dense_pkg::BIAS_W,
   parameter int N_IN       = 16,
   parameter int FRAC_SHIFT = 6,
   parameter int OUT_W      = myproject_dense_pkg::OUT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PROD_W-1:0] in_prod,
   input  logic signed [BIAS_W-1:0] in_bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat
);

   import myproject_dense_pkg::*;

   localparam int CNT_W = clog2(N_IN);
   localparam int ACC_W = (((PROD_W + CNT_W) > BIAS_W) ? (PROD_W + CNT_W) : BIAS_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

   acc_state_t              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;

   logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_base, acc_sum, rs_in;
   logic signed [OUT_W-1:0] fin_data;
   logic                    fin_sat;
   logic                    accept, drain, done;

   assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
   assign bias_ext = {{(ACC_W-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};
   assign acc_base = (cnt_q == '0) ? bias_ext : acc_q;
   assign acc_sum  = acc_base + prod_ext;

   // In ACC the freshly completed sum is finalised in the same cycle so the
   // result appears one cycle after the last product; in HOLD the parked sum.
   assign rs_in = (state_q == HOLD) ? acc_q : acc_sum;

   myproject_round_sat #(
      .ACC_W      (ACC_W),
      .FRAC_SHIFT (FRAC_SHIFT),
      .OUT_W      (OUT_W)
   ) u_round_sat (
      .acc_i  (rs_in),
      .data_o (fin_data),
      .sat_o  (fin_sat)
   );

   assign accept = in_valid && in_ready_q;
   assign drain  = out_valid_q && out_ready;
   assign done   = accept && (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      if (drain) out_valid_d = 1'b0;
      case (state_q)
         ACC: begin
            if (accept) begin
               acc_d = acc_sum;
               cnt_d = done ? '0 : cnt_q + 1'b1;
               if (done) begin
                  if (!out_valid_q || drain) begin
                     out_valid_d = 1'b1;
                     out_data_d  = fin_data;
                     out_sat_d   = fin_sat;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (drain) begin
               out_valid_d = 1'b1;
               out_data_d  = fin_data;
               out_sat_d   = fin_sat;
               state_d     = ACC;
            end
         end
         default: state_d = ACC;
      endcase
      // Registered from next state only, so never combinational on out_ready.
      in_ready_d = (state_d == ACC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACC;
         cnt_q       <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_myproject_dense_acc.sv
// -----------------------------------------------------------------------------
// tb_myproject_dense_acc
// Directed bench for myproject_dense_acc with N_IN=4, FRAC_SHIFT=6, OUT_W=16.
// Expected values are hand-computed from the rounding/saturation rules.
// -----------------------------------------------------------------------------
module tb_myproject_dense_acc;

   localparam int PROD_W     = 18;
   localparam int BIAS_W     = 24;
   localparam int N_IN       = 4;
   localparam int FRAC_SHIFT = 6;
   localparam int OUT_W      = 16;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [PROD_W-1:0] in_prod;
   logic signed [BIAS_W-1:0] in_bias;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_sat;

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;

   always #5 clk = ~clk;

   myproject_dense_acc #(
      .PROD_W     (PROD_W),
      .BIAS_W     (BIAS_W),
      .N_IN       (N_IN),
      .FRAC_SHIFT (FRAC_SHIFT),
      .OUT_W      (OUT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_bias   (in_bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one product and return #1 after the edge that accepted it.
   task automatic feed(input int p, input int b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_prod  = PROD_W'(p);
      in_bias  = BIAS_W'(b);
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
         stalls++;
      end
      if (n >= 50) check("accept_timeout", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int s0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_bias   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_sat", 32'(out_sat), 0);

      reset = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_out_valid", 32'(out_valid), 0);

      // Nominal: 64+128-32+0 = 160, (160+32)>>>6 = 3
      out_ready = 1'b1;
      feed(64, 0);
      feed(128, 0);
      feed(-32, 0);
      feed(0, 0);
      check("nom_valid", 32'(out_valid), 1);
      check("nom_data", 32'(out_data), 3);
      check("nom_sat", 32'(out_sat), 0);
      tick();
      check("nom_drained", 32'(out_valid), 0);

      // Positive saturation
      for (int i = 0; i < 4; i++) feed(131071, 8388607);
      check("pos_valid", 32'(out_valid), 1);
      check("pos_data", 32'(out_data), 32767);
      check("pos_sat", 32'(out_sat), 1);
      tick();

      // Negative saturation
      for (int i = 0; i < 4; i++) feed(-131072, -8388608);
      check("neg_valid", 32'(out_valid), 1);
`ifdef DENSE_ACC_RELU_EN
      check("neg_data", 32'(out_data), 0);
      check("neg_sat", 32'(out_sat), 0);
`else
      check("neg_data", 32'(out_data), -32768);
      check("neg_sat", 32'(out_sat), 1);
`endif
      tick();

      // Back-pressure across two neurons: 4*64 -> 4, 64+4*128 -> (576+32)>>>6 = 9
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed(64, 0);
      check("bp_first_valid", 32'(out_valid), 1);
      check("bp_first_data", 32'(out_data), 4);
      for (int i = 0; i < 4; i++) feed(128, 64);
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_hold_data", 32'(out_data), 4);
      tick();
      tick();
      check("bp_stable_data", 32'(out_data), 4);
      check("bp_stable_valid", 32'(out_valid), 1);
      check("bp_still_low", 32'(in_ready), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_second_valid", 32'(out_valid), 1);
      check("bp_second_data", 32'(out_data), 9);
      check("bp_in_ready_back", 32'(in_ready), 1);
      out_ready = 1'b1;
      tick();
      check("bp_drained", 32'(out_valid), 0);

      // Same-cycle drain: 3*64+192 = 384, (384+32)>>>6 = 6
      out_ready = 1'b0;
      s0 = stalls;
      for (int i = 0; i < 4; i++) feed(64, 0);
      check("sc_first_data", 32'(out_data), 4);
      for (int i = 0; i < 3; i++) feed(64, 0);
      check("sc_ready_before", 32'(in_ready), 1);
      out_ready = 1'b1;
      feed(192, 0);
      out_ready = 1'b0;
      check("sc_valid", 32'(out_valid), 1);
      check("sc_data", 32'(out_data), 6);
      check("sc_in_ready", 32'(in_ready), 1);
      check("sc_no_stall", stalls - s0, 0);

      // Reset mid-neuron with a result still held
      feed(64, 0);
      feed(64, 0);
      reset = 1'b0;
      #2;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data", 32'(out_data), 0);
      check("mid_rst_sat", 32'(out_sat), 0);
      check("mid_rst_in_ready", 32'(in_ready), 0);
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_release", 32'(in_ready), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) feed(64, 0);
      check("after_rst_valid", 32'(out_valid), 1);
      check("after_rst_data", 32'(out_data), 4);
      check("after_rst_sat", 32'(out_sat), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
